i2c_txn_arbiter: RTL and testbench

Round-robin scheduler that shares the single I2C master among N requesters. It accepts one transaction request at a time, drives the master's start/address/data/read-write inputs, and times the transfer with a fixed cycle count. It then returns completion, and read data when applicable, to the requester that was granted. The block sits between client logic (sensor pollers, config loaders) and the I2C master, and clocks on the same `clk`.

---
 rtl/i2c_txn_arbiter.sv | 113 +++++++++++
 tb/tb_i2c_txn_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master among N requesters.
// One transaction outstanding at a time, timed by a fixed cycle count.
module i2c_txn_arbiter #(
    parameter int N          = 4,
    parameter int TXN_CYCLES = 20,
    parameter int IDW        = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [7*N-1:0]   req_addr,
    input  logic [8*N-1:0]   req_data,
    input  logic [N-1:0]     req_rw,
    output logic [N-1:0]     req_ack,
    output logic [N-1:0]     done,
    output logic [7:0]       rdata,
    output logic             busy,
    output logic [IDW-1:0]   cur_id,
    output logic             m_start,
    output logic [6:0]       m_addr,
    output logic [7:0]       m_data,
    output logic             m_rw,
    input  logic [7:0]       m_data_read
);

    localparam int CW = $clog2(TXN_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           found;
    logic [CW-1:0]  cnt;

    logic [6:0] addr_a [N];
    logic [7:0] data_a [N];

    for (genvar g = 0; g < N; g++) begin : g_split
        assign addr_a[g] = req_addr[7*g +: 7];
        assign data_a[g] = req_data[8*g +: 8];
    end

    // Round-robin search: first requester at or after ptr wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Grant, issue and timing state machine; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            ptr     <= '0;
            cnt     <= '0;
            req_ack <= '0;
            done    <= '0;
            busy    <= 1'b0;
            m_start <= 1'b0;
            m_rw    <= 1'b0;
            rdata   <= '0;
            m_addr  <= '0;
            m_data  <= '0;
            cur_id  <= '0;
        end else begin
            req_ack <= '0;
            done    <= '0;
            m_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        m_addr       <= addr_a[win];
                        m_data       <= data_a[win];
                        m_rw         <= req_rw[win];
                        cur_id       <= win;
                        ptr          <= (win == IDW'(N - 1)) ? '0
                                        : win + IDW'(1);
                        req_ack[win] <= 1'b1;
                        m_start      <= 1'b1;
                        busy         <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= CW'(TXN_CYCLES - 1);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        done[cur_id] <= 1'b1;
                        rdata        <= m_rw ? m_data_read : 8'h00;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level model.
module tb_i2c_txn_arbiter;

    localparam int N   = 4;
    localparam int TXN = 20;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [7*N-1:0] req_addr;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_rw;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   done;
    logic [7:0]     rdata;
    logic           busy;
    logic [IDW-1:0] cur_id;
    logic           m_start;
    logic [6:0]     m_addr;
    logic [7:0]     m_data;
    logic           m_rw;
    logic [7:0]     m_data_read;

    i2c_txn_arbiter #(.N(N), .TXN_CYCLES(TXN)) dut (
        .clk(clk), .reset(reset), .req(req),
        .req_addr(req_addr), .req_data(req_data),
        .req_rw(req_rw), .req_ack(req_ack), .done(done),
        .rdata(rdata), .busy(busy), .cur_id(cur_id),
        .m_start(m_start), .m_addr(m_addr), .m_data(m_data),
        .m_rw(m_rw), .m_data_read(m_data_read)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model state
    int         edge_n = 0;
    bit         active = 0;
    int         g_edge = 0;
    int         ptr    = 0;
    int         e_cur  = 0;
    logic [N-1:0] e_ack  = '0;
    logic [N-1:0] e_done = '0;
    logic       e_busy  = 0;
    logic       e_start = 0;
    logic       e_rw    = 0;
    logic [6:0] e_addr  = '0;
    logic [7:0] e_data  = '0;
    logic [7:0] e_rdata = '0;

    // Observations from the DUT
    int dut_g[$];
    int dut_s[$];
    int ack_cnt [N];
    int done_cnt[N];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d got=%0h want=%0h",
                   tag, edge_n, obs, exp);
        end
    endtask

    task automatic model_edge();
        int w;
        edge_n++;
        e_ack   = '0;
        e_done  = '0;
        e_start = 0;
        if (reset) begin
            active  = 0;
            ptr     = 0;
            e_busy  = 0;
            e_rw    = 0;
            e_rdata = '0;
            e_addr  = '0;
            e_data  = '0;
            e_cur   = 0;
        end else if (active) begin
            if (edge_n == g_edge + TXN) begin
                e_done[e_cur] = 1'b1;
                e_rdata = e_rw ? m_data_read : 8'h00;
                e_busy  = 0;
                active  = 0;
            end
        end else if (req != '0) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && req[(ptr + k) % N]) w = (ptr + k) % N;
            e_cur    = w;
            e_addr   = req_addr[7*w +: 7];
            e_data   = req_data[8*w +: 8];
            e_rw     = req_rw[w];
            ptr      = (w + 1) % N;
            active   = 1;
            g_edge   = edge_n;
            e_ack[w] = 1'b1;
            e_start  = 1;
            e_busy   = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("req_ack", 32'(req_ack), 32'(e_ack));
        chk("done",    32'(done),    32'(e_done));
        chk("busy",    32'(busy),    32'(e_busy));
        chk("m_start", 32'(m_start), 32'(e_start));
        chk("cur_id",  32'(cur_id),  32'(e_cur));
        chk("m_addr",  32'(m_addr),  32'(e_addr));
        chk("m_data",  32'(m_data),  32'(e_data));
        chk("m_rw",    32'(m_rw),    32'(e_rw));
        chk("rdata",   32'(rdata),   32'(e_rdata));
        if (m_start) begin
            dut_g.push_back(int'(cur_id));
            dut_s.push_back(edge_n);
        end
        for (int i = 0; i < N; i++) begin
            ack_cnt[i]  += int'(req_ack[i]);
            done_cnt[i] += int'(done[i]);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (done == '0 && n < 3 * TXN);
    endtask

    task automatic clear_obs();
        dut_g.delete();
        dut_s.delete();
        for (int i = 0; i < N; i++) begin
            ack_cnt[i]  = 0;
            done_cnt[i] = 0;
        end
    endtask

    task automatic set_req(int i, logic [6:0] a, logic [7:0] d,
                           logic rw);
        req_addr[7*i +: 7] = a;
        req_data[8*i +: 8] = d;
        req_rw[i]          = rw;
    endtask

    initial begin
        int n;
        int exp3[5];
        int exp4[4];
        exp3 = '{0, 1, 2, 3, 0};
        exp4 = '{0, 3, 0, 3};
        reset = 1'b1;
        req = '0;
        req_addr = '0;
        req_data = '0;
        req_rw = '0;
        m_data_read = 8'h00;
        clear_obs();

        // Reset state
        step();
        step();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cur", 32'(cur_id), 32'h0);
        reset = 1'b0;
        step();

        // Single write on requester 0
        set_req(0, 7'h48, 8'h3C, 1'b0);
        req[0] = 1'b1;
        step();
        chk("t1_start", 32'(m_start), 32'h1);
        chk("t1_ack", 32'(req_ack), 32'h1);
        chk("t1_addr", 32'(m_addr), 32'h48);
        chk("t1_data", 32'(m_data), 32'h3C);
        req[0] = 1'b0;
        wait_done(n);
        chk("t1_lat", 32'(n), 32'(TXN));
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_rdata", 32'(rdata), 32'h0);

        // Single read on requester 2
        m_data_read = 8'hA5;
        set_req(2, 7'h1D, 8'h00, 1'b1);
        req[2] = 1'b1;
        step();
        chk("t2_ack", 32'(req_ack), 32'h4);
        req[2] = 1'b0;
        wait_done(n);
        chk("t2_lat", 32'(n), 32'(TXN));
        chk("t2_done", 32'(done), 32'h4);
        chk("t2_rdata", 32'(rdata), 32'hA5);
        chk("t2_cur", 32'(cur_id), 32'h2);

        // Contention: all four held from reset release
        reset = 1'b1;
        for (int i = 0; i < N; i++)
            set_req(i, 7'(8'h10 + i), 8'(8'h80 + i), 1'(i % 2));
        req = '1;
        step();
        reset = 1'b0;
        clear_obs();
        for (int c = 0; c < 4 * (TXN + 1) + 1; c++) step();
        chk("t3_cnt", 32'(dut_g.size()), 32'h5);
        for (int i = 0; i < 5; i++)
            chk("t3_order",
                32'((i < dut_g.size()) ? dut_g[i] : -1),
                32'(exp3[i]));
        for (int i = 1; i < 5; i++)
            chk("t3_gap",
                32'((i < dut_s.size()) ? dut_s[i] - dut_s[i-1] : -1),
                32'(TXN + 1));

        // Fairness: requesters 0 and 3 held
        reset = 1'b1;
        req = 4'b1001;
        step();
        reset = 1'b0;
        clear_obs();
        for (int c = 0; c < 3 * (TXN + 1) + 1; c++) step();
        chk("t4_cnt", 32'(dut_g.size()), 32'h4);
        for (int i = 0; i < 4; i++)
            chk("t4_order",
                32'((i < dut_g.size()) ? dut_g[i] : -1),
                32'(exp4[i]));

        // Withdrawn request during WAIT
        req = '0;
        for (int c = 0; c < TXN + 2; c++) step();
        clear_obs();
        req[0] = 1'b1;
        step();
        req[0] = 1'b0;
        for (int c = 0; c < 5; c++) step();
        req[1] = 1'b1;
        step();
        req[1] = 1'b0;
        for (int c = 0; c < 2 * TXN; c++) step();
        chk("t5_ack1", 32'(ack_cnt[1]), 32'h0);
        chk("t5_done1", 32'(done_cnt[1]), 32'h0);
        chk("t5_done0", 32'(done_cnt[0]), 32'h1);

        // Reset in the middle of a read
        clear_obs();
        m_data_read = 8'h5A;
        set_req(1, 7'h22, 8'h00, 1'b1);
        req[1] = 1'b1;
        step();
        req[1] = 1'b0;
        for (int c = 0; c < 9; c++) step();
        reset = 1'b1;
        step();
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_start", 32'(m_start), 32'h0);
        chk("t6_rdata", 32'(rdata), 32'h0);
        reset = 1'b0;
        set_req(3, 7'h33, 8'h44, 1'b0);
        req[3] = 1'b1;
        step();
        chk("t6_ack3", 32'(req_ack), 32'h8);
        req[3] = 1'b0;
        wait_done(n);
        chk("t6_lat", 32'(n), 32'(TXN));
        chk("t6_done1", 32'(done_cnt[1]), 32'h0);

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(3) == 0) begin
                    set_req(i, 7'($urandom), 8'($urandom),
                            1'($urandom));
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(7) == 0) begin
                    req[i] = 1'b0;
                end
            end
            m_data_read = 8'($urandom);
            reset = ($urandom_range(299) == 0);
            step();
        end
        reset = 1'b0;
        req = '0;
        for (int c = 0; c < TXN + 3; c++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
